// File: rtl/axil_cmd_master_if.sv
// AXI-Lite bus bundle shared by the command master and its register-file slave.
// Both sides are clocked by the master's clock/reset; the bundle carries no clock.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI-Lite bridge with a per-transaction timeout.
// All outputs, including the AXI valid/ready lines, come straight from registers.
module axil_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_timeout_o,
    axil_if.master                  m_axil
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]              state_r;
    logic [15:0]             cnt_r;
    logic                    cmd_ready_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    bready_r;
    logic                    arvalid_r;
    logic                    rready_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]              rsp_resp_r;
    logic                    rsp_timeout_r;

    logic aw_left_s;
    logic w_left_s;
    logic tmo_s;

    // A channel is still outstanding after this cycle only if its valid misses ready.
    assign aw_left_s = awvalid_r & ~m_axil.awready;
    assign w_left_s  = wvalid_r & ~m_axil.wready;
    assign tmo_s     = (cnt_r == TMO_LAST);

    // Transaction sequencer: command capture, AXI phases, timeout abort, response hold.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r       <= S_IDLE;
            cnt_r         <= 16'd0;
            cmd_ready_r   <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            wstrb_r       <= '0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        addr_r      <= cmd_addr_i;
                        wdata_r     <= cmd_wdata_i;
                        wstrb_r     <= cmd_wstrb_i;
                        cnt_r       <= 16'd0;
                        if (cmd_we_i) begin
                            state_r   <= S_WR_REQ;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            state_r   <= S_RD_REQ;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (!aw_left_s) awvalid_r <= 1'b0;
                    if (!w_left_s)  wvalid_r  <= 1'b0;
                    if (!aw_left_s && !w_left_s) begin
                        state_r  <= S_WR_RESP;
                        bready_r <= 1'b1;
                    end else if (tmo_s) begin
                        awvalid_r     <= 1'b0;
                        wvalid_r      <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= 2'b10;
                        rsp_rdata_r   <= '0;
                        rsp_timeout_r <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (m_axil.bvalid) begin
                        bready_r      <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= m_axil.bresp;
                        rsp_rdata_r   <= '0;
                        rsp_timeout_r <= 1'b0;
                    end else if (tmo_s) begin
                        bready_r      <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= 2'b10;
                        rsp_rdata_r   <= '0;
                        rsp_timeout_r <= 1'b1;
                    end
                end
                S_RD_REQ: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (m_axil.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= S_RD_RESP;
                    end else if (tmo_s) begin
                        arvalid_r     <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= 2'b10;
                        rsp_rdata_r   <= '0;
                        rsp_timeout_r <= 1'b1;
                    end
                end
                S_RD_RESP: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (m_axil.rvalid) begin
                        rready_r      <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= m_axil.rresp;
                        rsp_rdata_r   <= m_axil.rdata;
                        rsp_timeout_r <= 1'b0;
                    end else if (tmo_s) begin
                        rready_r      <= 1'b0;
                        state_r       <= S_RSP;
                        rsp_valid_r   <= 1'b1;
                        rsp_resp_r    <= 2'b10;
                        rsp_rdata_r   <= '0;
                        rsp_timeout_r <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cmd_ready_r <= 1'b0;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_resp_o    = rsp_resp_r;
    assign rsp_timeout_o = rsp_timeout_r;

    assign m_axil.awaddr  = addr_r;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_r;
    assign m_axil.wdata   = wdata_r;
    assign m_axil.wstrb   = wstrb_r;
    assign m_axil.wvalid  = wvalid_r;
    assign m_axil.bready  = bready_r;
    assign m_axil.araddr  = addr_r;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_r;
    assign m_axil.rready  = rready_r;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable-latency AXI-Lite slave.
module tb_axil_cmd_master;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;

    // slave behaviour settings
    logic [3:0]  aw_dly;
    logic [3:0]  w_dly;
    logic [3:0]  r_dly;
    logic        ar_block;
    logic        b_hold;
    logic [1:0]  bresp_k;
    logic [31:0] rdata_k;

    // slave state
    logic [3:0]  aw_cnt;
    logic [3:0]  w_cnt;
    logic [3:0]  r_cnt;
    logic        aw_got;
    logic        w_got;
    logic        r_pend;
    logic        bvalid_m;
    logic        rvalid_m;
    int          b_hs_cnt;

    axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_wstrb_i   (cmd_wstrb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_resp_o    (rsp_resp),
        .rsp_timeout_o (rsp_timeout),
        .m_axil        (bus)
    );

    always #5 clk = ~clk;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_dly);
    assign bus.arready = bus.arvalid && !ar_block;
    assign bus.bvalid  = bvalid_m;
    assign bus.bresp   = bresp_k;
    assign bus.rvalid  = rvalid_m;
    assign bus.rdata   = rdata_k;
    assign bus.rresp   = 2'b00;

    // Slave model: delayed AW/W ready, B after both, R a programmable delay after AR.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt   <= 4'd0;
            w_cnt    <= 4'd0;
            r_cnt    <= 4'd0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            r_pend   <= 1'b0;
            bvalid_m <= 1'b0;
            rvalid_m <= 1'b0;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 4'd1 : 4'd0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 4'd1 : 4'd0;
            if (bus.awvalid && bus.awready) aw_got <= 1'b1;
            if (bus.wvalid && bus.wready) w_got <= 1'b1;
            if (!bvalid_m && !b_hold && (aw_got || (bus.awvalid && bus.awready))
                && (w_got || (bus.wvalid && bus.wready))) begin
                bvalid_m <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (bvalid_m && bus.bready) begin
                bvalid_m <= 1'b0;
                b_hs_cnt <= b_hs_cnt + 1;
            end
            if (bus.arvalid && bus.arready) begin
                r_pend <= 1'b1;
                r_cnt  <= 4'd0;
            end else if (r_pend) begin
                if (r_cnt == r_dly) begin
                    rvalid_m <= 1'b1;
                    r_pend   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            if (rvalid_m && bus.rready) rvalid_m <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        cmd_addr  = 32'h0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        check(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        check("ready_back", {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        aw_dly = 4'd0; w_dly = 4'd0; r_dly = 4'd0; ar_block = 1'b0; b_hold = 1'b0;
        bresp_k = 2'b00; rdata_k = 32'h0; b_hs_cnt = 0;
        repeat (3) tick();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_awvalid", {63'd0, bus.awvalid}, 64'd0);
        check("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
        check("rst_resp", {62'd0, rsp_resp}, 64'd0);
        rstn = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

        // write, always-ready slave
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        check("wr_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("wr_awvalid", {63'd0, bus.awvalid}, 64'd1);
        check("wr_wvalid", {63'd0, bus.wvalid}, 64'd1);
        check("wr_awaddr", {32'd0, bus.awaddr}, 64'h4);
        check("wr_wdata", {32'd0, bus.wdata}, 64'hDEADBEEF);
        check("wr_wstrb", {60'd0, bus.wstrb}, 64'hF);
        check("wr_awprot", {61'd0, bus.awprot}, 64'd0);
        tick();
        check("wr_aw_drop", {63'd0, bus.awvalid}, 64'd0);
        check("wr_w_drop", {63'd0, bus.wvalid}, 64'd0);
        check("wr_bready", {63'd0, bus.bready}, 64'd1);
        check("wr_rsp_early", {63'd0, rsp_valid}, 64'd0);
        tick();
        check("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("wr_bready_off", {63'd0, bus.bready}, 64'd0);
        check("wr_resp", {62'd0, rsp_resp}, 64'd0);
        check("wr_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("wr_timeout", {63'd0, rsp_timeout}, 64'd0);
        consume();

        // read, data 5 cycles after AR
        r_dly = 4'd5; rdata_k = 32'h12345678;
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        check("rd_arvalid", {63'd0, bus.arvalid}, 64'd1);
        check("rd_araddr", {32'd0, bus.araddr}, 64'h8);
        check("rd_arprot", {61'd0, bus.arprot}, 64'd0);
        tick();
        check("rd_ar_drop", {63'd0, bus.arvalid}, 64'd0);
        check("rd_rready", {63'd0, bus.rready}, 64'd1);
        wait_rsp("rd_rsp_valid");
        check("rd_rdata", {32'd0, rsp_rdata}, 64'h12345678);
        check("rd_resp", {62'd0, rsp_resp}, 64'd0);
        check("rd_timeout", {63'd0, rsp_timeout}, 64'd0);
        consume();

        // AW accepted two cycles before W
        w_dly = 4'd2; bresp_k = 2'b10; b_hs_cnt = 0;
        issue(1'b1, 32'h10, 32'hA5A50F0F, 4'h3);
        check("split_both_valid", {62'd0, bus.awvalid, bus.wvalid}, 64'h3);
        tick();
        check("split_aw_drop", {63'd0, bus.awvalid}, 64'd0);
        check("split_w_held", {63'd0, bus.wvalid}, 64'd1);
        check("split_wdata1", {32'd0, bus.wdata}, 64'hA5A50F0F);
        tick();
        check("split_w_held2", {63'd0, bus.wvalid}, 64'd1);
        check("split_wdata2", {32'd0, bus.wdata}, 64'hA5A50F0F);
        check("split_wstrb", {60'd0, bus.wstrb}, 64'h3);
        check("split_no_bready", {63'd0, bus.bready}, 64'd0);
        tick();
        check("split_w_drop", {63'd0, bus.wvalid}, 64'd0);
        check("split_bready", {63'd0, bus.bready}, 64'd1);
        wait_rsp("split_rsp_valid");
        check("split_resp", {62'd0, rsp_resp}, 64'h2);
        check("split_timeout", {63'd0, rsp_timeout}, 64'd0);
        consume();
        check("split_single_b", 64'(b_hs_cnt), 64'd1);
        w_dly = 4'd0; bresp_k = 2'b00;

        // response back-pressure for 10 cycles
        r_dly = 4'd0; rdata_k = 32'hCAFE0001;
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        wait_rsp("bp_rsp_valid");
        held = rsp_rdata;
        check("bp_rdata", {32'd0, held}, 64'hCAFE0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_hold", {63'd0, rsp_valid}, 64'd1);
            check("bp_payload", {30'd0, rsp_resp, rsp_rdata}, {30'd0, 2'b00, 32'hCAFE0001});
            check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("bp_timeout", {63'd0, rsp_timeout}, 64'd0);
        end
        consume();

        // timeout with AR never accepted (TIMEOUT=16)
        ar_block = 1'b1; rdata_k = 32'hFFFFFFFF;
        issue(1'b0, 32'hC, 32'h0, 4'h0);
        check("to_arvalid_1", {63'd0, bus.arvalid}, 64'd1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("to_arvalid_hold", {63'd0, bus.arvalid}, 64'd1);
        end
        tick();
        check("to_arvalid_off", {63'd0, bus.arvalid}, 64'd0);
        check("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("to_resp", {62'd0, rsp_resp}, 64'h2);
        check("to_flag", {63'd0, rsp_timeout}, 64'd1);
        check("to_rdata", {32'd0, rsp_rdata}, 64'd0);
        ar_block = 1'b0;
        consume();

        // reset pulse while waiting for B
        b_hold = 1'b1; b_hs_cnt = 0;
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        tick();
        check("rw_in_wr_resp", {63'd0, bus.bready}, 64'd1);
        rstn = 1'b0;
        #1;
        check("rw_bready_async", {63'd0, bus.bready}, 64'd0);
        check("rw_cmd_ready_async", {63'd0, cmd_ready}, 64'd0);
        check("rw_rsp_valid_async", {63'd0, rsp_valid}, 64'd0);
        tick();
        tick();
        rstn = 1'b1; b_hold = 1'b0;
        tick();
        check("rw_ready_after", {63'd0, cmd_ready}, 64'd1);
        check("rw_no_rsp", {63'd0, rsp_valid}, 64'd0);
        issue(1'b1, 32'h24, 32'h55667788, 4'hF);
        check("rw_next_wdata", {32'd0, bus.wdata}, 64'h55667788);
        wait_rsp("rw_next_rsp");
        check("rw_next_resp", {62'd0, rsp_resp}, 64'd0);
        check("rw_next_timeout", {63'd0, rsp_timeout}, 64'd0);
        consume();
        check("rw_one_b", 64'(b_hs_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI-Lite and command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI-Lite and command data width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed per transaction before abort; legal range 2..65535.
REQ-004 SHALL have port clk_i  input  1: single clock for all logic and for m_axil.
REQ-005 SHALL have port rstn_i  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid_i  input  1: command present.
REQ-007 SHALL have port cmd_ready_o  output  1: command accepted when high together with cmd_valid_i.
REQ-008 SHALL have port cmd_we_i  input  1: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr_i  input  ADDR_WIDTH: byte address.
REQ-010 SHALL have port cmd_wdata_i  input  DATA_WIDTH: write data.
REQ-011 SHALL have port cmd_wstrb_i  input  DATA_WIDTH/8: write strobes.
REQ-012 SHALL have port rsp_valid_o  output  1: response present.
REQ-013 SHALL have port rsp_ready_i  input  1: response consumed when high together with rsp_valid_o.
REQ-014 SHALL have port rsp_rdata_o  output  DATA_WIDTH: read data; 0 for writes and timeouts.
REQ-015 SHALL have port rsp_resp_o  output  2: captured BRESP/RRESP; 2'b10 on timeout.
REQ-016 SHALL have port rsp_timeout_o  output  1: transaction was aborted by timeout.
REQ-017 SHALL have port m_axil  axil_if.master: AXI-Lite master toward the register-file slave; it is clocked by clk_i/rstn_i.

Function
REQ-018 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-019 SHALL drive cmd_ready_o = 1 only in IDLE; all command fields SHALL be registered on accept.
REQ-020 SHALL go IDLE->WR_REQ on an accepted command with cmd_we_i=1, and IDLE->RD_REQ on an accepted command with cmd_we_i=0.
REQ-021 SHALL assert awvalid and wvalid together in the first cycle of WR_REQ, which is the cycle after accept.
REQ-022 SHALL deassert awvalid and wvalid independently after their own handshakes, and SHALL hold awaddr/wdata/wstrb stable while the matching valid is high.
REQ-023 SHALL go WR_REQ->WR_RESP in the cycle after both AW and W are complete, including when both complete in the same cycle.
REQ-024 SHALL assert arvalid in RD_REQ until arready, then go to RD_RESP.
REQ-025 SHALL assert bready only in WR_RESP and rready only in RD_RESP.
REQ-026 SHALL, on the B or R handshake, capture bresp or rresp/rdata (rdata forced to 0 for writes) and go to RSP.
REQ-027 SHALL drive awprot = arprot = 3'b000.
REQ-028 SHALL hold rsp_valid_o = 1 with stable payload in RSP until rsp_ready_i; on handshake it SHALL go RSP->IDLE, so cmd_ready_o is high the following cycle.
REQ-029 SHALL clear the timeout counter on accept, increment it once per cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP, and not count in RSP.
REQ-030 SHALL, when the counter reaches TIMEOUT-1 without the terminating handshake, deassert all AXI valid/ready signals next cycle, go to RSP with resp 2'b10, rdata 0 and rsp_timeout_o = 1.
REQ-031 SHALL give a handshake precedence over a timeout that expires in the same cycle.
REQ-032 SHALL keep at most one transaction outstanding; minimum command-to-rsp_valid latency is 3 cycles with an always-ready slave.

Reset
REQ-033 SHALL, while rstn_i = 0, asynchronously force the state to IDLE, cmd_ready_o to 0, all AXI valids/readies, rsp_valid_o, rsp_timeout_o and the counter to 0, and rsp_rdata_o/rsp_resp_o to 0.
REQ-034 SHALL, on reset mid-transaction, drop the transaction with no response, and SHALL raise cmd_ready_o in the first cycle after rstn_i deasserts.

Verification
REQ-035 SHALL verify: write addr 0x4, data 0xDEADBEEF, strb 0xF, slave always ready -> AW/W in one cycle, bready, rsp_resp_o=0, rsp_valid_o 3 cycles after accept.
REQ-036 SHALL verify: read addr 0x8, slave returns 0x12345678 after 5 cycles -> rsp_rdata_o=0x12345678, rsp_resp_o=0, rsp_timeout_o=0.
REQ-037 SHALL verify: awready 2 cycles before wready -> awvalid drops early, wvalid held stable, single B accepted.
REQ-038 SHALL verify: TIMEOUT=16, slave never asserts arready -> arvalid low after 16 cycles, rsp_resp_o=2'b10, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-039 SHALL verify: rsp_ready_i low for 10 cycles -> rsp_valid_o and payload stable, cmd_ready_o low, no timeout.
REQ-040 SHALL verify: reset pulse in WR_RESP -> all outputs 0 immediately, no response, next command completes normally.
